// File: rtl/pump_scheduler_if.sv
// pump_scheduler_if: level/fault sensor inputs and pump/alarm outputs of the two-pump scheduler
interface pump_scheduler_if;
  logic       I;
  logic       S;
  logic       F1;
  logic       F2;
  logic       B1;
  logic       B2;
  logic [1:0] alarm;
  logic       lead;
  modport master (output I, S, F1, F2, input B1, B2, alarm, lead);
  modport slave  (input I, S, F1, F2, output B1, B2, alarm, lead);
endinterface

// File: rtl/pump_scheduler.sv
// pump_scheduler: two-pump level sequencer with duty alternation, minimum on-time and fault fallback; PUMP_SCHED_STAGGER_EN adds a staggered lag-pump start
module pump_scheduler #(
  parameter int MIN_ON  = 8,
  parameter int STAGGER = 4,
  parameter int CNT_W   = 8
) (
  input logic             clk,
  input logic             reset,
  pump_scheduler_if.slave bus
);
`ifdef PUMP_SCHED_STAGGER_EN
  typedef enum logic [2:0] {IDLE, ONE, BOTH, START_B, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, ONE, BOTH, ERR} state_t;
`endif
  if (MIN_ON >= 2**CNT_W || STAGGER >= 2**CNT_W) begin : g_bad_cfg
    $error("MIN_ON/STAGGER do not fit in CNT_W");
  end
  state_t           st, st_nx;
  logic             i_q, s_q, f1_q, f2_q;
  logic [CNT_W-1:0] on_cnt, on_nx;
  logic             run, run_nx, lead_q, lead_nx;
  logic             b1_q, b2_q, b1_nx, b2_nx, p1, p2, up;
  logic [1:0]       alarm_q, alarm_nx;
  logic             inv, d0, d1, d2, hold, active;
  assign inv  = ~i_q & s_q;
  assign d0   = i_q & s_q;
  assign d1   = i_q & ~s_q;
  assign d2   = ~i_q & ~s_q;
  assign hold = on_cnt != '0;
`ifdef PUMP_SCHED_STAGGER_EN
  logic [CNT_W-1:0] stg_cnt, stg_nx;
  assign active = st == ONE || st == BOTH || st == START_B;
`else
  assign active = st == ONE || st == BOTH;
`endif
  assign bus.B1    = b1_q;
  assign bus.B2    = b2_q;
  assign bus.alarm = alarm_q;
  assign bus.lead  = lead_q;
  always_comb begin
    st_nx   = st;
    run_nx  = run;
    lead_nx = lead_q;
    up      = 1'b0;
    on_nx   = (active && hold) ? on_cnt - 1'b1 : '0;
`ifdef PUMP_SCHED_STAGGER_EN
    stg_nx  = (st == START_B && stg_cnt != '0) ? stg_cnt - 1'b1 : '0;
`endif
    if (inv)
      st_nx = ERR;
    else
      case (st)
        IDLE, ERR: begin
          if (d1) begin
            st_nx   = ONE;
            run_nx  = lead_q;
            lead_nx = ~lead_q;
            up      = 1'b1;
          end else if (d2) begin
`ifdef PUMP_SCHED_STAGGER_EN
            st_nx  = START_B;
            stg_nx = CNT_W'(STAGGER);
`else
            st_nx  = BOTH;
`endif
            up     = 1'b1;
          end else
            st_nx = IDLE;
        end
        ONE: begin
          if (d2) begin
            st_nx = BOTH;
            up    = 1'b1;
          end else if (d0 && !hold)
            st_nx = IDLE;
        end
        BOTH: begin
          if (!d2 && !hold) begin
            st_nx  = d1 ? ONE : IDLE;
            run_nx = lead_q;
          end
        end
`ifdef PUMP_SCHED_STAGGER_EN
        START_B: begin
          if (d2 && stg_cnt <= CNT_W'(1))
            st_nx = BOTH;
          else if (!d2 && !hold) begin
            st_nx  = ONE;
            run_nx = lead_q;
          end
        end
`endif
        default: st_nx = IDLE;
      endcase
    // a single run moves to the healthy pump and restarts its hold
    if (st_nx == ONE && (run_nx ? f2_q & ~f1_q : f1_q & ~f2_q)) begin
      run_nx = ~run_nx;
      up     = 1'b1;
    end
    if (up)
      on_nx = CNT_W'(MIN_ON);
    p1 = st_nx == BOTH || (st_nx == ONE && !run_nx);
    p2 = st_nx == BOTH || (st_nx == ONE && run_nx);
`ifdef PUMP_SCHED_STAGGER_EN
    // lag pump waits for the stagger unless the lead pump is faulted
    if (st_nx == START_B) begin
      p1 = lead_q ? f2_q : 1'b1;
      p2 = lead_q ? 1'b1 : f1_q;
    end
`endif
    b1_nx    = p1 & ~f1_q;
    b2_nx    = p2 & ~f2_q;
    alarm_nx = (f1_q & f2_q) ? 2'b11 : inv ? 2'b01 : (f1_q | f2_q) ? 2'b10 : 2'b00;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st                     <= IDLE;
      {i_q, s_q, f1_q, f2_q} <= 4'b1100;
      on_cnt                 <= '0;
      run                    <= 1'b0;
      lead_q                 <= 1'b0;
      b1_q                   <= 1'b0;
      b2_q                   <= 1'b0;
      alarm_q                <= 2'b00;
    end else begin
      st                     <= st_nx;
      {i_q, s_q, f1_q, f2_q} <= {bus.I, bus.S, bus.F1, bus.F2};
      on_cnt                 <= on_nx;
      run                    <= run_nx;
      lead_q                 <= lead_nx;
      b1_q                   <= b1_nx;
      b2_q                   <= b2_nx;
      alarm_q                <= alarm_nx;
    end
  end
`ifdef PUMP_SCHED_STAGGER_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stg_cnt <= '0;
    else
      stg_cnt <= stg_nx;
  end
`endif
endmodule
